// File: rtl/syn_debug_probe.sv
// Host-side debug probe for a single-cycle CPU: run/step/stop control plus a
// serial dump of PC, register file and data memory over a valid/ready port.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 5
`endif

module syn_debug_probe #(
  parameter int DmWords = 32,
  parameter int CntBits = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  output logic                    cpu_en,
  input  logic                    cpu_halted,
  input  logic [31:0]             pc_dbg,
  output logic [4:0]              regfile_req_dbg,
  input  logic [31:0]             regfile_data_dbg,
  output logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg,
  input  logic [31:0]             datamem_data_dbg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    halt_seen,
  output logic [CntBits-1:0]      cycle_count
);

  localparam int LastIdx = 32 + DmWords;
  localparam int DmAw    = `DM_ADDR_BIT;
  localparam int IdxW    = ($clog2(LastIdx + 1) > DmAw + 1) ? $clog2(LastIdx + 1) : DmAw + 1;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DFETCH, S_DSEND} state_t;

  state_t           state, nxt;
  logic [IdxW-1:0]  idx;
  logic             accept, is_last, is_reg, is_dm;
  logic [31:0]      sel;

  assign accept  = cmd_valid && cmd_ready;
  assign is_last = (idx == IdxW'(LastIdx));
  assign is_reg  = (idx >= IdxW'(1)) && (idx <= IdxW'(32));
  assign is_dm   = (idx >= IdxW'(33));
  assign sel     = (idx == '0) ? pc_dbg : (is_reg ? regfile_data_dbg : datamem_data_dbg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Halt wins over STOP in RUN; RUN/STEP with a sticky halt are swallowed in IDLE.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN:  if (!halt_seen) nxt = S_RUN;
            OP_STEP: if (!halt_seen) nxt = S_STEP;
            OP_DUMP: nxt = S_DFETCH;
            default: nxt = S_IDLE;
          endcase
        end
      end
      S_RUN:    if (cpu_halted || (accept && cmd_op == OP_STOP)) nxt = S_IDLE;
      S_STEP:   nxt = S_IDLE;
      S_DFETCH: nxt = S_DSEND;
      S_DSEND:  if (out_ready) nxt = is_last ? S_IDLE : S_DFETCH;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready        = (state == S_IDLE) || (state == S_RUN);
    cpu_en           = (state == S_RUN) || (state == S_STEP);
    busy             = (state != S_IDLE);
    regfile_req_dbg  = '0;
    datamem_addr_dbg = '0;
    if (state == S_DFETCH) begin
      if (is_reg) regfile_req_dbg  = 5'(idx - IdxW'(1));
      if (is_dm)  datamem_addr_dbg = DmAw'(idx - IdxW'(33));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      halt_seen   <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (cpu_en && cpu_halted) halt_seen <= 1'b1;
      if (cpu_en && cycle_count != {CntBits{1'b1}}) cycle_count <= cycle_count + CntBits'(1);
      case (state)
        S_IDLE: idx <= '0;
        S_DFETCH: begin
          out_data  <= sel;
          out_valid <= 1'b1;
          out_last  <= is_last;
        end
        S_DSEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            idx       <= is_last ? '0 : idx + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_debug_probe.sv
// Directed bench for syn_debug_probe: step/run/halt/stop control, full dump with
// backpressure, and asynchronous reset abort, against a trivial CPU model.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 5
`endif

module tb_syn_debug_probe;
  localparam int DmWords = 4;
  localparam int CntBits = 32;

  logic                    clk, rst_n;
  logic                    cmd_valid, cmd_ready;
  logic [1:0]              cmd_op;
  logic                    cpu_en, cpu_halted;
  logic [31:0]             pc_dbg;
  logic [4:0]              regfile_req_dbg;
  logic [31:0]             regfile_data_dbg;
  logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg;
  logic [31:0]             datamem_data_dbg;
  logic                    out_valid, out_ready, out_last, busy, halt_seen;
  logic [31:0]             out_data;
  logic [CntBits-1:0]      cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  syn_debug_probe #(.DmWords(DmWords), .CntBits(CntBits)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cpu_en(cpu_en), .cpu_halted(cpu_halted), .pc_dbg(pc_dbg),
    .regfile_req_dbg(regfile_req_dbg), .regfile_data_dbg(regfile_data_dbg),
    .datamem_addr_dbg(datamem_addr_dbg), .datamem_data_dbg(datamem_data_dbg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .halt_seen(halt_seen), .cycle_count(cycle_count)
  );

  // CPU model: pc=0x40, r[k]=k, DM[j]=0x100+j
  assign pc_dbg           = 32'h40;
  assign regfile_data_dbg = 32'(regfile_req_dbg);
  assign datamem_data_dbg = 32'h100 + 32'(datamem_addr_dbg);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dump_exp(input int k);
    if (k == 0)  return 32'h40;
    if (k <= 32) return 32'(k - 1);
    return 32'h100 + 32'(k - 33);
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cpu_halted = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt_seen", halt_seen, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_regfile_req", regfile_req_dbg, 0);
    chk("rst_datamem_addr", datamem_addr_dbg, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // three STEP pulses
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'd1;
      tick();
      cmd_valid = 1'b0;
      chk("step_en", cpu_en, 1);
      chk("step_ready", cmd_ready, 0);
      tick();
      chk("step_en_off", cpu_en, 0);
      chk("step_ready_back", cmd_ready, 1);
    end
    chk("step_count", cycle_count, 3);

    // RUN, repeated RUN held 2 cycles is discarded, then STOP
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    chk("run_en", cpu_en, 1);
    tick();
    chk("run_hold1", cpu_en, 1);
    tick();
    chk("run_hold2", cpu_en, 1);
    cmd_op = 2'd3;
    tick();
    cmd_valid = 1'b0;
    chk("stop_en", cpu_en, 0);
    chk("stop_busy", busy, 0);
    chk("stop_count", cycle_count, 6);
    tick();
    chk("stop_stays_idle", cpu_en, 0);

    // reset mid-RUN aborts immediately
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("run2_en", cpu_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rstrun_en", cpu_en, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_count", cycle_count, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rstrun_quiet_en", cpu_en, 0);
    chk("rstrun_quiet_busy", busy, 0);

    // RUN, halt raised in the 11th cpu_en cycle
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("halt_pre_en", cpu_en, 1);
    chk("halt_pre_count", cycle_count, 10);
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    chk("halt_en", cpu_en, 0);
    chk("halt_seen", halt_seen, 1);
    chk("halt_count", cycle_count, 11);
    cmd_valid = 1'b1; cmd_op = 2'd0;
    tick();
    chk("halted_run_en", cpu_en, 0);
    chk("halted_run_busy", busy, 0);
    cmd_op = 2'd1;
    tick();
    cmd_valid = 1'b0;
    chk("halted_step_en", cpu_en, 0);
    tick();
    chk("halted_count", cycle_count, 11);

    // full dump, backpressure on word 3
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0;
    chk("dump_busy", busy, 1);
    chk("dump_ready", cmd_ready, 0);
    for (int k = 0; k < 33 + DmWords; k++) begin
      chk("dfetch_valid", out_valid, 0);
      chk("dfetch_cpu_en", cpu_en, 0);
      chk("dfetch_rf_req", regfile_req_dbg, (k >= 1 && k <= 32) ? k - 1 : 0);
      chk("dfetch_dm_addr", datamem_addr_dbg, (k >= 33) ? k - 33 : 0);
      tick();
      chk("dsend_valid", out_valid, 1);
      chk("dsend_data", out_data, dump_exp(k));
      chk("dsend_last", out_last, (k == 32 + DmWords) ? 1 : 0);
      if (k == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, 32'd2);
          chk("stall_last", out_last, 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("dump_done_valid", out_valid, 0);
    chk("dump_done_busy", busy, 0);

    // reset during DSEND of word 10
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); tick(); end
    tick();
    chk("pre_rst_data", out_data, dump_exp(10));
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstdump_valid", out_valid, 0);
    chk("rstdump_busy", busy, 0);
    chk("rstdump_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rstdump_quiet_valid", out_valid, 0);
    chk("rstdump_quiet_busy", busy, 0);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("redump_valid", out_valid, 1);
    chk("redump_data", out_data, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/syn_debug_probe.md
SYN_DEBUG_PROBE -- requirements
Module: syn_debug_probe

Interface
REQ-001 SHALL have parameter DmWords, default 32, number of data-memory words dumped; legal range 1..2**`DM_ADDR_BIT.
REQ-002 SHALL have parameter CntBits, default 32, cycle-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  host command strobe.
REQ-006 cmd_ready  output  1  probe accepts a command this cycle.
REQ-007 cmd_op  input  2  command: 0 RUN, 1 STEP, 2 DUMP, 3 STOP.
REQ-008 cpu_en  output  1  drives the CPU en input.
REQ-009 cpu_halted  input  1  CPU halted output.
REQ-010 pc_dbg  input  32  CPU byte PC.
REQ-011 regfile_req_dbg  output  5  CPU register debug index.
REQ-012 regfile_data_dbg  input  32  CPU register debug data, combinational from regfile_req_dbg.
REQ-013 datamem_addr_dbg  output  `DM_ADDR_BIT  CPU data-memory debug word address.
REQ-014 datamem_data_dbg  input  32  CPU data-memory debug data, combinational from datamem_addr_dbg.
REQ-015 out_valid  output  1  dump word available.
REQ-016 out_ready  input  1  host accepts dump word.
REQ-017 out_data  output  32  dump word, registered.
REQ-018 out_last  output  1  final word of the dump, qualified by out_valid.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 halt_seen  output  1  sticky: cpu_halted was sampled high while cpu_en=1.
REQ-021 cycle_count  output  CntBits  number of cycles with cpu_en=1, saturating.

Function
REQ-022 States: IDLE, RUN, STEP, DFETCH, DSEND; command accepted when cmd_valid && cmd_ready.
REQ-023 cmd_ready SHALL be 1 in IDLE and RUN, 0 in STEP, DFETCH and DSEND.
REQ-024 IDLE: RUN -> RUN; STEP -> STEP; DUMP -> DFETCH with index 0; STOP -> no-op, stay IDLE.
REQ-025 RUN: cpu_en=1 each cycle in RUN; STOP accepted -> IDLE next cycle, cpu_en=0 from that cycle; RUN/STEP/DUMP accepted in RUN are discarded.
REQ-026 RUN: cpu_halted=1 sampled -> IDLE next cycle, halt_seen set; halt takes priority over a simultaneous STOP (same result).
REQ-027 STEP: cpu_en=1 for exactly one cycle, then IDLE; halted sampled during that cycle sets halt_seen.
REQ-028 RUN/STEP commands accepted while halt_seen=1 SHALL be consumed with no cpu_en pulse and stay in IDLE.
REQ-029 cycle_count increments by 1 on every cycle with cpu_en=1; holds at all-ones, no wrap.
REQ-030 Dump order, index k: k=0 pc_dbg; k=1..32 register k-1 (r0..r31); k=33..32+DmWords DM word k-33; total 33+DmWords words.
REQ-031 DFETCH: drive regfile_req_dbg/datamem_addr_dbg from index (unused port holds 0); next edge captures selected data into out_data, out_valid=1, -> DSEND.
REQ-032 DSEND: out_data and out_last stable while out_valid && !out_ready; on out_ready: last word -> IDLE with out_valid=0, otherwise index+1 -> DFETCH.
REQ-033 out_valid SHALL not be asserted in consecutive cycles across words (one DFETCH bubble per word); cpu_en=0 throughout DFETCH/DSEND.
REQ-034 out_last=1 only on word index 32+DmWords.

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, cpu_en=0, out_valid=0, out_last=0, out_data=0, busy=0, halt_seen=0, cycle_count=0, index 0, regfile_req_dbg=0, datamem_addr_dbg=0.
REQ-036 Reset mid-RUN or mid-dump SHALL abort with no further cpu_en pulse or out_valid; after release, only a new command restarts activity.

Verification
REQ-037 STEP x3 from reset, CPU not halted -> three single-cycle cpu_en pulses, cycle_count=3, cmd_ready low only in the pulse cycles.
REQ-038 RUN, cpu_halted raised after 10 cpu_en cycles -> cpu_en drops next cycle, halt_seen=1, cycle_count=11; subsequent RUN gives no cpu_en.
REQ-039 DUMP with DmWords=4, out_ready=1, model pc=0x40, rk=k, DM[j]=0x100+j -> 37 words 0x40,0..31,0x100..0x103; out_last only on final word.
REQ-040 DUMP with out_ready low 5 cycles on word 3 -> out_data holds value of r2, no index advance, no dropped or duplicated word.
REQ-041 RUN then STOP in same cycle as a second RUN held for 2 cycles -> STOP accepted, IDLE, trailing RUN ignored only while in RUN.
REQ-042 rst_n asserted during DSEND of word 10 -> out_valid=0 and busy=0 immediately; after release out_valid stays 0 until new DUMP, which restarts at pc_dbg.
